// File: rtl/psum_out_fifo_if.sv
// Handshake bundle between the PE datapath, the psum output FIFO and its consumer.
// The FIFO takes the slave modport; the producer/consumer side takes master.
interface psum_out_fifo_if #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned ADDR_LEN = 3
);
    logic                    clr;
    logic                    wen;
    logic signed [WIDTH-1:0] din;
    logic                    full;
    logic                    almost_full;
    logic                    rd_valid;
    logic                    rd_ready;
    logic signed [WIDTH-1:0] rd_data;
    logic [ADDR_LEN:0]       count;
    logic                    overflow;

    modport master (
        output clr, wen, din, rd_ready,
        input  full, almost_full, rd_valid, rd_data, count, overflow
    );

    modport slave (
        input  clr, wen, din, rd_ready,
        output full, almost_full, rd_valid, rd_data, count, overflow
    );
endinterface

// File: rtl/psum_out_fifo.sv
// Circular FIFO buffering finished partial sums from the PE datapath.
// Status flags decode from the registered count; read data falls through from the head slot.
module psum_out_fifo #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned ADDR_LEN = 3
) (
    input logic              clk,
    input logic              rst,
    psum_out_fifo_if.slave   bus
);
    localparam logic [ADDR_LEN:0] FULL_CNT = (ADDR_LEN+1)'(DEPTH);
    localparam logic [ADDR_LEN:0] AF_CNT   = (ADDR_LEN+1)'(DEPTH - 1);

    logic signed [WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_LEN-1:0]     wptr_q, wptr_d;
    logic [ADDR_LEN-1:0]     rptr_q, rptr_d;
    logic [ADDR_LEN:0]       count_q, count_d;
    logic                    ovf_q, ovf_d;
    logic                    full, rd_valid;
    logic                    wr_acc, rd_acc, mem_we;

    assign full     = (count_q == FULL_CNT);
    assign rd_valid = (count_q != '0);
    assign wr_acc   = bus.wen & ~full;
    assign rd_acc   = rd_valid & bus.rd_ready;
    assign mem_we   = wr_acc & ~bus.clr;

    assign bus.full        = full;
    assign bus.rd_valid    = rd_valid;
    assign bus.almost_full = (count_q >= AF_CNT);
    assign bus.count       = count_q;
    assign bus.overflow    = ovf_q;
    assign bus.rd_data     = mem_q[rptr_q];

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        if (bus.clr) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
            ovf_d   = 1'b0;
        end else begin
            if (wr_acc) wptr_d = wptr_q + ADDR_LEN'(1);
            if (rd_acc) rptr_d = rptr_q + ADDR_LEN'(1);
            // full is judged on the current count, so a read never frees room for a same-cycle write
            if (bus.wen && full) ovf_d = 1'b1;
            case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + (ADDR_LEN+1)'(1);
                2'b01:   count_d = count_q - (ADDR_LEN+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem_q[wptr_q] <= bus.din;
    end
endmodule

// File: tb/tb_psum_out_fifo.sv
// Self-checking bench for psum_out_fifo: directed scenarios then random traffic,
// compared against a queue-based reference model.
module tb_psum_out_fifo;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    logic signed [15:0] q [$];
    logic               m_ovf = 1'b0;

    psum_out_fifo_if #(.WIDTH(16), .ADDR_LEN(3)) bus ();

    psum_out_fifo #(.WIDTH(16), .DEPTH(DEPTH), .ADDR_LEN(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        int n;
        n = q.size();
        chk({tag, ".count"}, 32'(bus.count), 32'(n));
        chk({tag, ".full"}, 32'(bus.full), 32'(n == DEPTH));
        chk({tag, ".almost_full"}, 32'(bus.almost_full), 32'(n >= DEPTH - 1));
        chk({tag, ".rd_valid"}, 32'(bus.rd_valid), 32'(n != 0));
        chk({tag, ".overflow"}, 32'(bus.overflow), 32'(m_ovf));
        if (n != 0) chk({tag, ".rd_data"}, 32'(bus.rd_data), 32'(q[0]));
    endtask

    // One clock: drive inputs, advance the model from the pre-edge state, check after the edge.
    task automatic step(input string tag, input logic w, input logic signed [15:0] d,
                        input logic r, input logic c);
        bit was_full;
        bus.wen = w; bus.din = d; bus.rd_ready = r; bus.clr = c;
        was_full = (q.size() == DEPTH);
        if (c) begin
            q.delete();
            m_ovf = 1'b0;
        end else begin
            if (r && q.size() != 0) begin
                chk({tag, ".pop"}, 32'(bus.rd_data), 32'(q[0]));
                void'(q.pop_front());
            end
            if (w && was_full) m_ovf = 1'b1;
            if (w && !was_full) q.push_back(d);
        end
        @(posedge clk);
        #1;
        bus.wen = 1'b0; bus.rd_ready = 1'b0; bus.clr = 1'b0;
        check_outputs(tag);
    endtask

    task automatic drain(input string tag);
        int guard;
        guard = 0;
        while (q.size() != 0 && guard < 2 * DEPTH) begin
            step(tag, 1'b0, '0, 1'b1, 1'b0);
            guard++;
        end
        chk({tag, ".empty"}, 32'(bus.rd_valid), 32'(0));
    endtask

    initial begin
        bus.wen = 1'b0; bus.din = '0; bus.rd_ready = 1'b0; bus.clr = 1'b0;
        #12 rst = 1'b0;
        @(posedge clk); #1;
        check_outputs("reset");
        step("idle", 1'b0, '0, 1'b0, 1'b0);

        step("first_wr", 1'b1, 16'sd5, 1'b0, 1'b0);
        chk("first_wr.data5", 32'(bus.rd_data), 32'(16'sd5));
        drain("first_drain");

        for (int i = 1; i <= 8; i++) step("fill", 1'b1, 16'(i), 1'b0, 1'b0);
        chk("fill.full", 32'(bus.full), 32'(1));
        step("ovf_wr", 1'b1, 16'sd99, 1'b0, 1'b0);
        chk("ovf_wr.sticky", 32'(bus.overflow), 32'(1));
        for (int i = 1; i <= 8; i++) begin
            chk("ovf_drain.order", 32'(bus.rd_data), 32'(i));
            step("ovf_drain", 1'b0, '0, 1'b1, 1'b0);
        end
        chk("ovf_drain.empty", 32'(bus.count), 32'(0));
        step("ovf_clr", 1'b0, '0, 1'b0, 1'b1);

        for (int i = 1; i <= 6; i++) step("wrap_w1", 1'b1, 16'(i), 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step("wrap_r", 1'b0, '0, 1'b1, 1'b0);
        chk("wrap.word6", 32'(bus.rd_data), 32'(6));
        for (int i = 10; i <= 15; i++) step("wrap_w2", 1'b1, 16'(i), 1'b0, 1'b0);
        drain("wrap_drain");

        for (int i = 0; i < 4; i++) step("half_fill", 1'b1, 16'(40 + i), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step("half_rw", 1'b1, 16'(50 + i), 1'b1, 1'b0);
        chk("half_rw.count", 32'(bus.count), 32'(4));
        drain("half_drain");

        for (int i = 0; i < 8; i++) step("full_fill", 1'b1, 16'(-100 + i), 1'b0, 1'b0);
        step("full_rw", 1'b1, 16'sd77, 1'b1, 1'b0);
        chk("full_rw.count7", 32'(bus.count), 32'(7));
        drain("full_drain");
        step("clr_ovf", 1'b0, '0, 1'b0, 1'b1);
        step("empty_rw", 1'b1, 16'sd33, 1'b1, 1'b0);
        chk("empty_rw.count1", 32'(bus.count), 32'(1));
        drain("empty_drain");

        for (int i = 0; i < 5; i++) step("clr_fill", 1'b1, 16'(i), 1'b0, 1'b0);
        step("clr_wen", 1'b1, 16'sd123, 1'b0, 1'b1);
        chk("clr_wen.rd_valid", 32'(bus.rd_valid), 32'(0));

        for (int i = 0; i < 3; i++) step("rst_fill", 1'b1, 16'(i), 1'b0, 1'b0);
        step("rst_ovf", 1'b0, '0, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        q.delete();
        m_ovf = 1'b0;
        check_outputs("async_rst");
        #1 rst = 1'b0;
        @(posedge clk); #1;
        check_outputs("post_rst");

        for (int i = 0; i < 400; i++) begin
            logic w, r, c;
            w = ($urandom_range(0, 99) < 60);
            r = ($urandom_range(0, 99) < 45);
            c = ($urandom_range(0, 99) < 2);
            step("rand", w, 16'($urandom), r, c);
        end
        drain("rand_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout observed=running expected=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/psum_out_fifo.md
Name: psum_out_fifo

Overview:
- Output buffer directly downstream of the PE datapath.
- Captures each finished partial sum, signalled by the datapath's outbuf_write strobe with its module_outval word, into a circular FIFO.
- Returns backpressure through full, which the datapath receives as outbuf_full.
- Drains to the next stage (output collector / next PE psum input) over a valid/ready handshake with first-word-fall-through read data.

Parameters:
WIDTH, 16, data word width; equals the datapath PSUM_SCRATCH_WIDTH.
DEPTH, 8, number of entries; must be a power of two, at least 2.
ADDR_LEN, 3, pointer width; log2(DEPTH).

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
clr  input  1  synchronous flush; empties the FIFO and clears overflow.
wen  input  1  write strobe from the datapath (outbuf_write).
din  input  WIDTH  signed psum word from the datapath (module_outval).
full  output  1  FIFO full; drives the datapath outbuf_full.
almost_full  output  1  count >= DEPTH-1.
rd_valid  output  1  head word available.
rd_ready  input  1  consumer accepts the head word.
rd_data  output  WIDTH  head word, first-word-fall-through.
count  output  ADDR_LEN+1  current occupancy, 0..DEPTH.
overflow  output  1  sticky; set when a write arrives while full.

Behaviour:
- Reset: one clock; rst is asynchronous and active-high. It clears wptr, rptr and count to 0 and overflow to 0.
- Outputs at reset: full=0, almost_full=0, rd_valid=0, count=0. rd_data is don't-care because memory contents are not reset.
- Storage: DEPTH x WIDTH register array.
  - Write port is synchronous.
  - Read is combinational: rd_data = mem[rptr].
- Status outputs are all decoded from registered count, so they are glitch-free and valid in the same cycle as the count:
  - full = (count == DEPTH)
  - rd_valid = (count != 0)
  - almost_full = (count >= DEPTH-1)
- Write accept: wr_acc = wen & ~full.
  - On acceptance, mem[wptr] <= din and wptr <= wptr+1, wrapping modulo DEPTH.
  - Written data is visible on rd_data the next cycle when the FIFO was empty (latency 1).
- Read accept: rd_acc = rd_valid & rd_ready. On acceptance, rptr <= rptr+1, wrapping modulo DEPTH.
- Count update:
  - +1 on wr_acc only.
  - -1 on rd_acc only.
  - Unchanged when both accept or neither accepts.
- Simultaneous read and write:
  - Not full and not empty: both accepted; count unchanged.
  - Full: only the read is accepted. The write is rejected because full is evaluated from the current count, not the post-read count. overflow is set.
  - Empty: only the write is accepted, since rd_valid=0; there is no bypass.
- Overflow: wen & full sets overflow on the next edge. It holds until rst or clr. Rejected data is discarded and pointers do not move.
- Underflow is impossible by construction: rd_ready while rd_valid=0 is ignored and produces no pointer change.
- clr:
  - Synchronous; has priority over wen and rd_ready in the same cycle.
  - Next state: wptr=rptr=count=0, overflow=0. No write is performed in that cycle.
- Reset mid-operation: all state clears immediately (asynchronous) and in-flight words are lost. The datapath sees full=0 during and after reset.
- Data is treated as an opaque signed WIDTH-bit word: no arithmetic, no sign extension.
- Ordering is strict FIFO; the pointer wrap from DEPTH-1 to 0 must preserve order.

Test Plan:
- Reset, then idle: count=0, rd_valid=0, full=0, overflow=0. Then write din=16'sd5 for one cycle: the next cycle gives rd_valid=1, rd_data=5, count=1.
- Fill, then overflow: 8 consecutive writes of values 1..8 with rd_ready=0 give count=8, full=1, almost_full=1 after the 7th write. A 9th write of value 99 sets overflow=1 and count stays 8. Draining then yields exactly 1..8 in order, with no 99.
- Wrap-around: write 6 words, read 5, write 6 more (values 10..15), then drain. Reads return word 6 followed by 10..15, and count returns to 0.
- Simultaneous read and write at half occupancy (count=4, wen=1, rd_ready=1 for 3 cycles): count stays 4 and the output order is preserved.
- Full with simultaneous read and write: count drops to 7, full deasserts next cycle, the written word is absent and overflow=1. Empty with simultaneous read and write: count becomes 1.
- Flush and asynchronous reset:
  - clr asserted together with wen at count=5: count=0 and overflow=0 next cycle, and rd_valid=0 (the write is dropped).
  - rst pulsed between clock edges at count=3: all outputs return to reset values without waiting for a clock edge.
